unidade_controle: RTL and testbench



---
 rtl/unidade_controle_pkg.sv | 52 +++++
 rtl/decodificador_instrucao.sv | 60 ++++++
 rtl/unidade_controle.sv | 172 +++++++++++++++++
 tb/tb_unidade_controle.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// ---------------------------------------------------------------------------
// unidade_controle_pkg
// Shared definitions for the control unit:
//   - 4-bit opcode constants (instruction bits [7:4])
//   - FSM state encoding (also driven out on estado_out)
//   - alu_op and sel_fonte_a encodings
// Optional feature macro used by the top: UNIDADE_CONTROLE_PASSO_EN
// ---------------------------------------------------------------------------
package unidade_controle_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_STB = 4'b0101;
  localparam logic [3:0] OP_LDC = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;

  // FSM states
  typedef enum logic [1:0] {
    BUSCA      = 2'b00,
    DECODIFICA = 2'b01,
    EXECUTA    = 2'b10,
    ESPERA_MEM = 2'b11
  } estado_t;

  // ALU operation
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // A-register source
  typedef enum logic [1:0] {
    FONTE_ALU  = 2'b00,
    FONTE_MEM  = 2'b01,
    FONTE_IMED = 2'b10
  } fonte_a_t;

  // Everything above BEQ is undefined and runs as a NOP.
  function automatic logic opcode_invalido_f(input logic [3:0] op);
    return op > OP_BEQ;
  endfunction

endpackage

// File: rtl/decodificador_instrucao.sv
// ---------------------------------------------------------------------------
// decodificador_instrucao
// Purely combinational opcode-to-control mapping.
// Ports:
//   opcode_i        in  4  instruction opcode
//   carrega_a_o     out 1  A load strobe for the EXECUTA cycle
//   mem_escreve_o   out 1  memory write strobe for the EXECUTA cycle
//   sel_dado_mem_o  out 1  write-data source (0 = A, 1 = B)
//   alu_op_o        out 2  ALU operation for ALU instructions
//   sel_fonte_a_o   out 2  A source for the EXECUTA cycle
//   le_memoria_o    out 1  LDA/LDB: needs the ESPERA_MEM cycle
//   destino_b_o     out 1  memory read goes to B (LDB) rather than A (LDA)
//   salto_jmp_o     out 1  conditional JMP
//   salto_beq_o     out 1  conditional BEQ
//   invalido_o      out 1  undefined opcode
// ---------------------------------------------------------------------------
module decodificador_instrucao
  import unidade_controle_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       carrega_a_o,
  output logic       mem_escreve_o,
  output logic       sel_dado_mem_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] sel_fonte_a_o,
  output logic       le_memoria_o,
  output logic       destino_b_o,
  output logic       salto_jmp_o,
  output logic       salto_beq_o,
  output logic       invalido_o
);

  always_comb begin
    carrega_a_o    = 1'b0;
    mem_escreve_o  = 1'b0;
    sel_dado_mem_o = 1'b0;
    alu_op_o       = ALU_ADD;
    sel_fonte_a_o  = FONTE_ALU;
    le_memoria_o   = 1'b0;
    destino_b_o    = 1'b0;
    salto_jmp_o    = 1'b0;
    salto_beq_o    = 1'b0;
    invalido_o     = opcode_invalido_f(opcode_i);
    case (opcode_i)
      OP_ADD: begin carrega_a_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_SUB: begin carrega_a_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_AND: begin carrega_a_o = 1'b1; alu_op_o = ALU_AND; end
      OP_OR:  begin carrega_a_o = 1'b1; alu_op_o = ALU_OR;  end
      OP_LDC: begin carrega_a_o = 1'b1; sel_fonte_a_o = FONTE_IMED; end
      OP_STA: begin mem_escreve_o = 1'b1; sel_dado_mem_o = 1'b0; end
      OP_STB: begin mem_escreve_o = 1'b1; sel_dado_mem_o = 1'b1; end
      OP_LDA: begin le_memoria_o = 1'b1; end
      OP_LDB: begin le_memoria_o = 1'b1; destino_b_o = 1'b1; end
      OP_JMP: salto_jmp_o = 1'b1;
      OP_BEQ: salto_beq_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// ---------------------------------------------------------------------------
// unidade_controle
// Multi-cycle control unit: BUSCA -> DECODIFICA -> EXECUTA [-> ESPERA_MEM].
// All outputs are registered; the strobes are computed on the edge that
// enters the state in which they must be visible.
// Optional feature: define UNIDADE_CONTROLE_PASSO_EN to add the 'passo'
// input; BUSCA then waits until passo=1 is sampled (single-step debug).
// Ports:
//   clk, reset            clock / synchronous active-high reset
//   passo                 (optional) single-step advance from BUSCA
//   instrucao_in[7:0]     ROM word: [7:4] opcode, [3:0] operand
//   a_zero, b_zero, a_igual_b  datapath flags, sampled in EXECUTA
//   pc_out[7:0]           program counter / ROM address
//   alu_op[1:0], sel_fonte_a[1:0], carrega_a, carrega_b,
//   mem_escreve, mem_endereco[3:0], sel_dado_mem   datapath control
//   estado_out[1:0]       current FSM state
//   opcode_invalido       sticky undefined-opcode flag
// Parameters: PC_ULTIMO (last address before wrap), PC_RESET.
// ---------------------------------------------------------------------------
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int PC_ULTIMO = 15,
  parameter int PC_RESET  = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef UNIDADE_CONTROLE_PASSO_EN
  input  logic       passo,
`endif
  input  logic [7:0] instrucao_in,
  input  logic       a_zero,
  input  logic       b_zero,
  input  logic       a_igual_b,
  output logic [7:0] pc_out,
  output logic [1:0] alu_op,
  output logic [1:0] sel_fonte_a,
  output logic       carrega_a,
  output logic       carrega_b,
  output logic       mem_escreve,
  output logic [3:0] mem_endereco,
  output logic       sel_dado_mem,
  output logic [1:0] estado_out,
  output logic       opcode_invalido
);

  localparam logic [7:0] PC_ULTIMO_L = 8'(PC_ULTIMO);
  localparam logic [7:0] PC_RESET_L  = 8'(PC_RESET);

  estado_t    estado_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic       carrega_a_q;
  logic       carrega_b_q;
  logic       mem_escreve_q;
  logic [1:0] alu_op_q;
  logic [1:0] sel_fonte_a_q;
  logic       sel_dado_mem_q;
  logic       invalido_q;

  // Decoder input: while in DECODIFICA the IR is being loaded this very
  // edge, so decode the ROM word directly to have the EXECUTA strobes
  // registered in time; afterwards decode the held IR.
  logic [3:0] opcode_dec_d;
  assign opcode_dec_d = (estado_q == DECODIFICA) ? instrucao_in[7:4] : ir_q[7:4];

  logic       dec_carrega_a;
  logic       dec_mem_escreve;
  logic       dec_sel_dado_mem;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_sel_fonte_a;
  logic       dec_le_memoria;
  logic       dec_destino_b;
  logic       dec_salto_jmp;
  logic       dec_salto_beq;
  logic       dec_invalido;

  decodificador_instrucao u_dec (
    .opcode_i       (opcode_dec_d),
    .carrega_a_o    (dec_carrega_a),
    .mem_escreve_o  (dec_mem_escreve),
    .sel_dado_mem_o (dec_sel_dado_mem),
    .alu_op_o       (dec_alu_op),
    .sel_fonte_a_o  (dec_sel_fonte_a),
    .le_memoria_o   (dec_le_memoria),
    .destino_b_o    (dec_destino_b),
    .salto_jmp_o    (dec_salto_jmp),
    .salto_beq_o    (dec_salto_beq),
    .invalido_o     (dec_invalido)
  );

  logic avanca_busca_d;
`ifdef UNIDADE_CONTROLE_PASSO_EN
  assign avanca_busca_d = passo;
`else
  assign avanca_busca_d = 1'b1;
`endif

  // A PC at or above PC_ULTIMO (e.g. after an out-of-range branch) wraps.
  logic [7:0] pc_inc_d;
  logic       salto_d;
  logic [7:0] pc_next_d;
  assign pc_inc_d  = (pc_q >= PC_ULTIMO_L) ? 8'd0 : pc_q + 8'd1;
  assign salto_d   = (dec_salto_jmp & a_zero & b_zero) | (dec_salto_beq & a_igual_b);
  assign pc_next_d = salto_d ? {4'b0000, ir_q[3:0]} : pc_inc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q       <= BUSCA;
      pc_q           <= PC_RESET_L;
      ir_q           <= 8'h00;
      carrega_a_q    <= 1'b0;
      carrega_b_q    <= 1'b0;
      mem_escreve_q  <= 1'b0;
      alu_op_q       <= ALU_ADD;
      sel_fonte_a_q  <= FONTE_ALU;
      sel_dado_mem_q <= 1'b0;
      invalido_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle: default them off every edge.
      carrega_a_q    <= 1'b0;
      carrega_b_q    <= 1'b0;
      mem_escreve_q  <= 1'b0;
      alu_op_q       <= ALU_ADD;
      sel_fonte_a_q  <= FONTE_ALU;
      sel_dado_mem_q <= 1'b0;
      case (estado_q)
        BUSCA: begin
          if (avanca_busca_d) estado_q <= DECODIFICA;
        end
        DECODIFICA: begin
          ir_q           <= instrucao_in;
          estado_q       <= EXECUTA;
          carrega_a_q    <= dec_carrega_a;
          mem_escreve_q  <= dec_mem_escreve;
          alu_op_q       <= dec_alu_op;
          sel_fonte_a_q  <= dec_sel_fonte_a;
          sel_dado_mem_q <= dec_sel_dado_mem;
          invalido_q     <= invalido_q | dec_invalido;
        end
        EXECUTA: begin
          if (dec_le_memoria) begin
            estado_q      <= ESPERA_MEM;
            carrega_a_q   <= ~dec_destino_b;
            carrega_b_q   <= dec_destino_b;
            sel_fonte_a_q <= FONTE_MEM;
          end else begin
            estado_q <= BUSCA;
            pc_q     <= pc_next_d;
          end
        end
        ESPERA_MEM: begin
          estado_q <= BUSCA;
          pc_q     <= pc_inc_d;
        end
        default: estado_q <= BUSCA;
      endcase
    end
  end

  assign pc_out          = pc_q;
  assign alu_op          = alu_op_q;
  assign sel_fonte_a     = sel_fonte_a_q;
  assign carrega_a       = carrega_a_q;
  assign carrega_b       = carrega_b_q;
  assign mem_escreve     = mem_escreve_q;
  assign mem_endereco    = ir_q[3:0];
  assign sel_dado_mem    = sel_dado_mem_q;
  assign estado_out      = estado_q;
  assign opcode_invalido = invalido_q;

endmodule

// File: tb/tb_unidade_controle.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle
// Drives the control unit from a small ROM array and checks it against an
// instruction-level model: each fetched instruction expands into the list of
// per-cycle outputs it must produce, which a compare process pops one per
// cycle. Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instrucao_in;
  logic       a_zero, b_zero, a_igual_b;
  logic [7:0] pc_out;
  logic [1:0] alu_op, sel_fonte_a, estado_out;
  logic       carrega_a, carrega_b, mem_escreve, sel_dado_mem, opcode_invalido;
  logic [3:0] mem_endereco;
`ifdef UNIDADE_CONTROLE_PASSO_EN
  logic       passo = 1'b1;
`endif

  logic [7:0] rom [0:255];
  assign instrucao_in = rom[pc_out];

  always #5 clk = ~clk;

  unidade_controle #(.PC_ULTIMO(15), .PC_RESET(0)) dut (
    .clk             (clk),
    .reset           (reset),
`ifdef UNIDADE_CONTROLE_PASSO_EN
    .passo           (passo),
`endif
    .instrucao_in    (instrucao_in),
    .a_zero          (a_zero),
    .b_zero          (b_zero),
    .a_igual_b       (a_igual_b),
    .pc_out          (pc_out),
    .alu_op          (alu_op),
    .sel_fonte_a     (sel_fonte_a),
    .carrega_a       (carrega_a),
    .carrega_b       (carrega_b),
    .mem_escreve     (mem_escreve),
    .mem_endereco    (mem_endereco),
    .sel_dado_mem    (sel_dado_mem),
    .estado_out      (estado_out),
    .opcode_invalido (opcode_invalido)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Values sampled at each rising edge (what the DUT saw there).
  logic rst_e = 1'b0, az_e = 1'b0, bz_e = 1'b0, eq_e = 1'b0;
  int   cyc = 0;
  always @(posedge clk) begin
    rst_e <= reset;
    az_e  <= a_zero;
    bz_e  <= b_zero;
    eq_e  <= a_igual_b;
    cyc   <= reset ? 1 : cyc + 1;
  end

  // ---------------- instruction-level model ----------------
  typedef struct {
    logic [1:0] st;
    logic [7:0] pc;
    logic       ca, cb, me;
    logic [1:0] alu, sel;
    logic       dado;
    logic       addr_chk;
    logic [3:0] addr;
    logic       inv;
  } rec_t;

  rec_t       q[$];
  logic [7:0] m_pc;
  logic       m_inv;
  logic [7:0] prev_instr;
  logic       prev_valid;

  task automatic gen_instr();
    logic [7:0] ins;
    logic [3:0] op, opd;
    rec_t r;
    ins = rom[m_pc];
    op  = ins[7:4];
    opd = ins[3:0];
    r = '{st: 2'd0, pc: m_pc, ca: 1'b0, cb: 1'b0, me: 1'b0, alu: 2'd0, sel: 2'd0,
          dado: 1'b0, addr_chk: 1'b0, addr: 4'd0, inv: m_inv};
    q.push_back(r);                 // fetch
    r.st = 2'd1;
    q.push_back(r);                 // decode
    if (op >= 4'd11) m_inv = 1'b1;
    r.st = 2'd2; r.inv = m_inv; r.addr_chk = 1'b1; r.addr = opd;
    case (op)
      4'd0:  begin r.ca = 1'b1; r.alu = 2'd0; end
      4'd1:  begin r.ca = 1'b1; r.alu = 2'd1; end
      4'd8:  begin r.ca = 1'b1; r.alu = 2'd2; end
      4'd9:  begin r.ca = 1'b1; r.alu = 2'd3; end
      4'd6:  begin r.ca = 1'b1; r.sel = 2'd2; end
      4'd3:  begin r.me = 1'b1; end
      4'd5:  begin r.me = 1'b1; r.dado = 1'b1; end
      default: ;
    endcase
    q.push_back(r);                 // execute
    if (op == 4'd2 || op == 4'd4) begin
      r.st = 2'd3; r.ca = (op == 4'd2); r.cb = (op == 4'd4); r.sel = 2'd1;
      q.push_back(r);               // memory wait
    end
    prev_instr = ins;
    prev_valid = 1'b1;
  endtask

  task automatic cmp_rec(input rec_t r);
    chk("estado", estado_out, r.st);
    chk("pc_out", pc_out, r.pc);
    chk("carrega_a", carrega_a, r.ca);
    chk("carrega_b", carrega_b, r.cb);
    chk("mem_escreve", mem_escreve, r.me);
    chk("alu_op", alu_op, r.alu);
    chk("sel_fonte_a", sel_fonte_a, r.sel);
    chk("sel_dado_mem", sel_dado_mem, r.dado);
    chk("opcode_invalido", opcode_invalido, r.inv);
    if (r.addr_chk) chk("mem_endereco", mem_endereco, r.addr);
  endtask

  // Compare process: one expected record per cycle.
  initial begin
    logic started;
    logic [3:0] pop, ppd;
    rec_t r;
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_e) begin
        started = 1'b1;
        chk("rst_estado", estado_out, 2'd0);
        chk("rst_pc", pc_out, 8'd0);
        chk("rst_strobes", {carrega_a, carrega_b, mem_escreve}, 3'b000);
        chk("rst_sel", {alu_op, sel_fonte_a, sel_dado_mem}, 5'd0);
        chk("rst_mem_endereco", mem_endereco, 4'd0);
        chk("rst_invalido", opcode_invalido, 1'b0);
        q.delete();
        m_pc = 8'd0; m_inv = 1'b0; prev_valid = 1'b0;
        gen_instr();
        void'(q.pop_front());       // fetch cycle coincides with reset cycle
      end else if (started) begin
        if (q.size() == 0) begin
          if (prev_valid) begin
            pop = prev_instr[7:4];
            ppd = prev_instr[3:0];
            if ((pop == 4'd7 && az_e && bz_e) || (pop == 4'd10 && eq_e))
              m_pc = {4'd0, ppd};
            else
              m_pc = (m_pc >= 8'd15) ? 8'd0 : m_pc + 8'd1;
          end
          gen_instr();
        end
        r = q.pop_front();
        cmp_rec(r);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_scn();
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_zero = 1'b0; b_zero = 1'b0; a_igual_b = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (cyc != k && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: cycle %0d not reached, at %0d", k, cyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_zero = 1'b0; b_zero = 1'b0; a_igual_b = 1'b0;

    // LDC 1 / STA 7 / LDB 7
    begin_scn();
    rom[0] = 8'h61; rom[1] = 8'h37; rom[2] = 8'h47;
    release_rst();
    wait_cyc(3);  chk("s1_c3_carrega_a", carrega_a, 1'b1); chk("s1_c3_sel", sel_fonte_a, 2'b10);
    wait_cyc(6);  chk("s1_c6_mem_escreve", mem_escreve, 1'b1); chk("s1_c6_endereco", mem_endereco, 4'd7);
    wait_cyc(10); chk("s1_c10_carrega_b", carrega_b, 1'b1); chk("s1_c10_sel", sel_fonte_a, 2'b01);
    wait_cyc(11); chk("s1_c11_pc", pc_out, 8'd3);

    // SUB then ADD
    begin_scn();
    rom[0] = 8'h10; rom[1] = 8'h00;
    release_rst();
    wait_cyc(3); chk("s2_sub_alu", alu_op, 2'b01); chk("s2_sub_ca", carrega_a, 1'b1);
    wait_cyc(4); chk("s2_ca_one_cycle", carrega_a, 1'b0);
    wait_cyc(6); chk("s2_add_alu", alu_op, 2'b00); chk("s2_add_ca", carrega_a, 1'b1);

    // JMP taken
    begin_scn();
    rom[0] = 8'h7F; a_zero = 1'b1; b_zero = 1'b1;
    rom[15] = 8'h61;
    release_rst();
    wait_cyc(4); chk("s3_jmp_taken_pc", pc_out, 8'd15);
    wait_cyc(7); chk("s3_wrap_pc", pc_out, 8'd0);

    // JMP not taken
    begin_scn();
    rom[0] = 8'h7F; a_zero = 1'b1; b_zero = 1'b0;
    release_rst();
    wait_cyc(4); chk("s4_jmp_not_taken_pc", pc_out, 8'd1);

    // BEQ taken
    begin_scn();
    rom[0] = 8'hAC; a_igual_b = 1'b1;
    release_rst();
    wait_cyc(4); chk("s5_beq_pc", pc_out, 8'd12);

    // Undefined opcode, sticky flag
    begin_scn();
    rom[0] = 8'hB3; rom[1] = 8'h00;
    release_rst();
    wait_cyc(2); chk("s6_inv_before", opcode_invalido, 1'b0);
    wait_cyc(3); chk("s6_inv_set", opcode_invalido, 1'b1);
                 chk("s6_no_strobes", {carrega_a, carrega_b, mem_escreve}, 3'b000);
    wait_cyc(6); chk("s6_inv_sticky", opcode_invalido, 1'b1); chk("s6_next_ca", carrega_a, 1'b1);

    // Reset during ESPERA_MEM of LDB
    begin_scn();
    rom[0] = 8'h45;
    release_rst();
    wait_cyc(1); chk("s7_inv_cleared", opcode_invalido, 1'b0);
    wait_cyc(4); chk("s7_espera", estado_out, 2'd3); chk("s7_cb", carrega_b, 1'b1);
    reset = 1'b1;
    wait_cyc(1); chk("s7_abort_cb", carrega_b, 1'b0); chk("s7_abort_pc", pc_out, 8'd0);
                 chk("s7_abort_estado", estado_out, 2'd0);

    // Mixed program checked by the model only, including wrap-around
    begin_scn();
    rom[0] = 8'h61; rom[1] = 8'h82; rom[2] = 8'h93; rom[3] = 8'h25;
    rom[4] = 8'h5A; rom[5] = 8'hF0; rom[6] = 8'hA9; rom[9] = 8'h70;
    rom[10] = 8'h34; rom[11] = 8'h1E;
    a_igual_b = 1'b1;
    release_rst();
    repeat (90) @(posedge clk);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
